// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and round-robin helper for async_req_arbiter
package arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  localparam int ARB_MAX_REQ = 16;

  // Nearest set bit after last wins; scanning from the farthest inward leaves it last-assigned.
  function automatic int rr_pick(input logic [ARB_MAX_REQ-1:0] pend, input int last, input int n);
    int idx;
    rr_pick = last;
    for (int k = n; k >= 1; k--) begin
      idx = (last + k) % n;
      if (pend[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/sync_high.sv
// rtl/sync_high.sv - two-flop synchronizer that resets high (idle level of request lines)
module sync_high (
  input  logic clk,
  input  logic n_rst,
  input  logic d,
  output logic q
);

  logic s1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1 <= 1'b1;
      q  <= 1'b1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/async_req_arbiter.sv
// rtl/async_req_arbiter.sv - round-robin arbiter for async active-low request strobes with ack/timeout
module async_req_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [NUM_REQ-1:0]         async_req_n,
  input  logic                       ack,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [NUM_REQ-1:0]         pending,
  output logic                       overflow,
  output logic                       timeout
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [TW-1:0] T_MAX  = {TW{1'b1}};

  logic [NUM_REQ-1:0] sync_q, prev_q, fall, clr, pending_d;
  logic               overflow_d, grant_load, tmo_hit;
  logic [IDW-1:0]     winner, last_id, last_id_d, grant_id_d;
  logic [NUM_REQ-1:0] grant_d;
  logic               grant_valid_d, timeout_d;
  logic [TW-1:0]      timer, timer_d;
  arb_state_t         state, state_d;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_sync
    sync_high u_sync (
      .clk   (clk),
      .n_rst (n_rst),
      .d     (async_req_n[i]),
      .q     (sync_q[i])
    );
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) prev_q <= '1;
    else        prev_q <= sync_q;
  end

  // A fresh edge in the clearing cycle survives as a new pending request.
  always_comb begin
    fall       = prev_q & ~sync_q;
    winner     = IDW'(rr_pick(ARB_MAX_REQ'(pending), int'(last_id), NUM_REQ));
    grant_load = (state == IDLE) && (|pending);
    clr        = grant_load ? (NUM_REQ'(1) << winner) : '0;
    pending_d  = (pending & ~clr) | fall;
    overflow_d = |(fall & pending & ~clr);
    tmo_hit    = (TIMEOUT != 0) && (state == GRANT) && !ack && (timer == T_LAST);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      pending     <= '0;
      overflow    <= 1'b0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      timeout     <= 1'b0;
      timer       <= '0;
      last_id     <= IDW'(NUM_REQ - 1);
    end else begin
      state       <= state_d;
      pending     <= pending_d;
      overflow    <= overflow_d;
      grant       <= grant_d;
      grant_valid <= grant_valid_d;
      grant_id    <= grant_id_d;
      timeout     <= timeout_d;
      timer       <= timer_d;
      last_id     <= last_id_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (grant_load) state_d = GRANT;
      GRANT:   if (ack || tmo_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ack takes priority over the timeout terminal count (tmo_hit already requires !ack).
  always_comb begin
    grant_d       = grant;
    grant_valid_d = grant_valid;
    grant_id_d    = grant_id;
    timer_d       = timer;
    last_id_d     = last_id;
    timeout_d     = 1'b0;
    case (state)
      IDLE: begin
        grant_d       = '0;
        grant_valid_d = 1'b0;
        grant_id_d    = '0;
        if (grant_load) begin
          grant_d       = NUM_REQ'(1) << winner;
          grant_valid_d = 1'b1;
          grant_id_d    = winner;
          timer_d       = '0;
          last_id_d     = winner;
        end
      end
      GRANT: begin
        if (ack || tmo_hit) begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          grant_id_d    = '0;
          timeout_d     = tmo_hit;
        end else if (timer != T_MAX) begin
          timer_d = timer + 1'b1;
        end
      end
      default: begin
        grant_d       = '0;
        grant_valid_d = 1'b0;
        grant_id_d    = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_async_req_arbiter.sv
// tb/tb_async_req_arbiter.sv - directed self-checking bench for async_req_arbiter
module tb_async_req_arbiter;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [3:0] async_req_n;
  logic       ack;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic [3:0] pending;
  logic       overflow;
  logic       timeout;

  int n_cmp = 0;
  int n_bad = 0;

  async_req_arbiter #(.NUM_REQ(4), .TIMEOUT(8)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .async_req_n (async_req_n),
    .ack         (ack),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .pending     (pending),
    .overflow    (overflow),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    async_req_n = 4'hF;
    ack = 1'b0;
    tick(2);
    n_rst = 1'b1;
    tick(1);
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    async_req_n = 4'hF;
    ack = 1'b0;
    tick(3);
    n_cmp++;
    if ({grant, grant_valid, grant_id, pending, overflow, timeout} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got grant=%b gv=%b id=%0d pend=%b ovf=%b tmo=%b, need all 0",
               grant, grant_valid, grant_id, pending, overflow, timeout);
    end
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      n_cmp++;
      if ({grant_valid, pending, overflow, timeout} !== 7'd0) begin
        n_bad++;
        $display("FAIL reset_release_%0d: got gv=%b pend=%b ovf=%b tmo=%b, need 0", i,
                 grant_valid, pending, overflow, timeout);
      end
    end
  endtask

  task automatic test_single_request();
    async_req_n = 4'b1101;
    tick(2);
    n_cmp++;
    if (pending !== 4'b0000) begin
      n_bad++;
      $display("FAIL single_pend_early: got %b need 0000", pending);
    end
    tick(1);
    n_cmp++;
    if (pending !== 4'b0010 || grant !== 4'b0000) begin
      n_bad++;
      $display("FAIL single_pend_e3: got pend=%b grant=%b need 0010/0000", pending, grant);
    end
    tick(1);
    n_cmp++;
    if (grant !== 4'b0010 || grant_id !== 2'd1 || grant_valid !== 1'b1 || pending !== 4'b0000) begin
      n_bad++;
      $display("FAIL single_grant_e4: got grant=%b id=%0d gv=%b pend=%b need 0010/1/1/0000",
               grant, grant_id, grant_valid, pending);
    end
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    n_cmp++;
    if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_ack_clear: got grant=%b gv=%b need 0000/0", grant, grant_valid);
    end
    async_req_n = 4'hF;
    tick(3);
  endtask

  task automatic test_simultaneous();
    logic [1:0] exp_id [3];
    logic [3:0] one;
    exp_id[0] = 2'd0;
    exp_id[1] = 2'd2;
    exp_id[2] = 2'd3;
    do_reset();
    async_req_n = 4'b0010;
    tick(3);
    for (int j = 0; j < 3; j++) begin
      tick(1);
      one = 4'b0001 << exp_id[j];
      n_cmp++;
      if (grant_valid !== 1'b1 || grant_id !== exp_id[j] || grant !== one) begin
        n_bad++;
        $display("FAIL simul_grant_%0d: got gv=%b id=%0d grant=%b need 1/%0d/%b",
                 j, grant_valid, grant_id, grant, exp_id[j], one);
      end
      tick(1);
      n_cmp++;
      if (grant !== one) begin
        n_bad++;
        $display("FAIL simul_hold_%0d: got %b need %b", j, grant, one);
      end
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      n_cmp++;
      if (grant_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL simul_idle_%0d: got gv=%b need 0", j, grant_valid);
      end
    end
    async_req_n = 4'hF;
    tick(3);
  endtask

  task automatic test_fairness();
    async_req_n = 4'b0110;
    tick(4);
    n_cmp++;
    if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
      n_bad++;
      $display("FAIL fair_first: got gv=%b id=%0d need 1/0", grant_valid, grant_id);
    end
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    tick(1);
    n_cmp++;
    if (grant_valid !== 1'b1 || grant_id !== 2'd3) begin
      n_bad++;
      $display("FAIL fair_second: got gv=%b id=%0d need 1/3", grant_valid, grant_id);
    end
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    async_req_n = 4'hF;
    tick(3);
  endtask

  task automatic test_timeout();
    async_req_n = 4'b1011;
    tick(4);
    n_cmp++;
    if (grant !== 4'b0100 || grant_id !== 2'd2) begin
      n_bad++;
      $display("FAIL tmo_grant: got grant=%b id=%0d need 0100/2", grant, grant_id);
    end
    for (int k = 1; k < 8; k++) begin
      tick(1);
      n_cmp++;
      if (grant !== 4'b0100 || timeout !== 1'b0) begin
        n_bad++;
        $display("FAIL tmo_hold_%0d: got grant=%b tmo=%b need 0100/0", k, grant, timeout);
      end
    end
    tick(1);
    n_cmp++;
    if (timeout !== 1'b1 || grant !== 4'b0000 || grant_valid !== 1'b0 || pending !== 4'b0000) begin
      n_bad++;
      $display("FAIL tmo_fire: got tmo=%b grant=%b gv=%b pend=%b need 1/0000/0/0000",
               timeout, grant, grant_valid, pending);
    end
    tick(1);
    n_cmp++;
    if (timeout !== 1'b0 || grant_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL tmo_pulse_end: got tmo=%b gv=%b need 0/0", timeout, grant_valid);
    end
    async_req_n = 4'hF;
    tick(3);
  endtask

  task automatic test_overflow();
    int ov_cnt;
    int g1_cnt;
    logic prev_g1;
    async_req_n = 4'b1110;
    tick(4);
    n_cmp++;
    if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
      n_bad++;
      $display("FAIL ovf_hold_grant: got gv=%b id=%0d need 1/0", grant_valid, grant_id);
    end
    async_req_n = 4'b1100;
    tick(3);
    n_cmp++;
    if (pending !== 4'b0010) begin
      n_bad++;
      $display("FAIL ovf_pend: got %b need 0010", pending);
    end
    async_req_n = 4'b1110;
    tick(2);
    async_req_n = 4'b1100;
    ov_cnt = 0;
    g1_cnt = 0;
    prev_g1 = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick(1);
      if (overflow === 1'b1) ov_cnt++;
      if (grant_valid === 1'b1 && grant_id === 2'd1 && !prev_g1) g1_cnt++;
      prev_g1 = (grant_valid === 1'b1 && grant_id === 2'd1);
      ack = prev_g1;
    end
    ack = 1'b0;
    n_cmp++;
    if (ov_cnt != 1) begin
      n_bad++;
      $display("FAIL ovf_pulse_count: got %0d need 1", ov_cnt);
    end
    n_cmp++;
    if (g1_cnt != 1) begin
      n_bad++;
      $display("FAIL ovf_grant_count: got %0d need 1", g1_cnt);
    end
    n_cmp++;
    if (pending !== 4'b0000) begin
      n_bad++;
      $display("FAIL ovf_pend_final: got %b need 0000", pending);
    end
    async_req_n = 4'hF;
    tick(3);
  endtask

  task automatic test_reset_mid_grant();
    async_req_n = 4'b0011;
    tick(4);
    n_cmp++;
    if (grant_valid !== 1'b1 || grant_id !== 2'd2 || pending !== 4'b1000) begin
      n_bad++;
      $display("FAIL midrst_pre: got gv=%b id=%0d pend=%b need 1/2/1000", grant_valid, grant_id, pending);
    end
    #2;
    n_rst = 1'b0;
    async_req_n = 4'hF;
    #1;
    n_cmp++;
    if ({grant, grant_valid, grant_id, pending, overflow, timeout} !== 13'd0) begin
      n_bad++;
      $display("FAIL midrst_async: got grant=%b gv=%b id=%0d pend=%b ovf=%b tmo=%b need all 0",
               grant, grant_valid, grant_id, pending, overflow, timeout);
    end
    @(negedge clk);
    tick(1);
    n_rst = 1'b1;
    tick(4);
    n_cmp++;
    if (grant_valid !== 1'b0 || pending !== 4'b0000) begin
      n_bad++;
      $display("FAIL midrst_after: got gv=%b pend=%b need 0/0000", grant_valid, pending);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0;
    async_req_n = 4'hF;
    ack = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_request();
    test_simultaneous();
    test_fairness();
    test_timeout();
    test_overflow();
    test_reset_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
